// File: rtl/data_mem_responder_pkg.sv
// Shared types and Funct3 codes for the data-memory responder.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int MAX_WAIT = 15;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
    typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_BAD} dmem_op_t;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Datapath <-> data-memory request/response bundle.
interface data_mem_responder_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              MemRead;
    logic              MemWrite;
    logic [2:0]        Funct3;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              ready;
    logic              mem_err;

    modport master (
        output MemRead, MemWrite, Funct3, addr, wr_data,
        input  rd_data, ready, mem_err
    );

    modport slave (
        input  MemRead, MemWrite, Funct3, addr, wr_data,
        output rd_data, ready, mem_err
    );
endinterface

// File: rtl/data_mem_responder_lane_align.sv
// RV32 sub-word lane steering: byte enables, replicated store word,
// sign/zero-extended load value and misaligned/illegal detection.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  lane_i,
    input  logic        is_store_i,
    input  logic [31:0] wr_data_i,
    input  logic [31:0] ram_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] st_word_o,
    output logic [31:0] ld_data_o,
    output logic        err_o
);
    logic        misalign;
    logic        illegal;
    logic        sx;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        misalign = ((funct3_i[1:0] == 2'b01) && lane_i[0]) ||
                   ((funct3_i == F3_W) && (lane_i != 2'b00));
        // Unsigned variants exist only for loads.
        illegal  = !f3_legal(funct3_i) || (is_store_i && funct3_i[2]);
        err_o    = misalign || illegal;
        sx       = !funct3_i[2];
        byte_sel = ram_word_i[{lane_i, 3'b000} +: 8];
        half_sel = lane_i[1] ? ram_word_i[31:16] : ram_word_i[15:0];

        be_o      = 4'b0000;
        st_word_o = wr_data_i;
        ld_data_o = '0;
        case (funct3_i[1:0])
            2'b00: begin
                be_o      = 4'b0001 << lane_i;
                st_word_o = {4{wr_data_i[7:0]}};
                ld_data_o = {{24{sx & byte_sel[7]}}, byte_sel};
            end
            2'b01: begin
                be_o      = lane_i[1] ? 4'b1100 : 4'b0011;
                st_word_o = {2{wr_data_i[15:0]}};
                ld_data_o = {{16{sx & half_sel[15]}}, half_sel};
            end
            2'b10: begin
                be_o      = 4'b1111;
                ld_data_o = ram_word_i;
            end
            default: ;
        endcase

        if (err_o) begin
            be_o      = 4'b0000;
            ld_data_o = '0;
        end
    end
endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: latched request, WAIT_CYCLES wait states, one-cycle
// ready pulse; RAM commit and load sampling happen on the edge entering RESP.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int         WORDS     = 1 << (ADDR_W - 2);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmem_state_t       state_q;
    logic [3:0]        cnt_q;
    dmem_op_t          op_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              ready_q;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [WORDS];

    logic              req, in_idle, commit, fail, we;
    dmem_op_t          op_in, cur_op;
    logic [2:0]        cur_f3;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata, ram_word, st_word, ld_data;
    logic [3:0]        be;
    logic              align_err;

    // With zero wait states the commit edge is the accept edge, so the
    // live request feeds the lane logic while idle; otherwise the latches.
    always_comb begin
        req       = bus.MemRead | bus.MemWrite;
        in_idle   = (state_q == IDLE);
        op_in     = (bus.MemRead && bus.MemWrite) ? OP_BAD :
                    bus.MemWrite ? OP_STORE : OP_LOAD;
        cur_op    = in_idle ? op_in       : op_q;
        cur_f3    = in_idle ? bus.Funct3  : f3_q;
        cur_addr  = in_idle ? bus.addr    : addr_q;
        cur_wdata = in_idle ? bus.wr_data : wdata_q;
        ram_word  = mem[cur_addr[ADDR_W-1:2]];
        commit    = in_idle ? (req && (WAIT_CYCLES == 0))
                            : ((state_q == WAIT) && (cnt_q == 4'd0));
        fail      = align_err || (cur_op == OP_BAD);
        we        = commit && !fail && (cur_op == OP_STORE);
        rd_data_d = (fail || (cur_op != OP_LOAD)) ? '0 : ld_data;
        err_d     = fail;
    end

    dmem_lane_align u_align (
        .funct3_i   (cur_f3),
        .lane_i     (cur_addr[1:0]),
        .is_store_i (cur_op == OP_STORE),
        .wr_data_i  (cur_wdata),
        .ram_word_i (ram_word),
        .be_o       (be),
        .st_word_o  (st_word),
        .ld_data_o  (ld_data),
        .err_o      (align_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            op_q      <= OP_LOAD;
            f3_q      <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ready_q <= commit;
            if (commit) begin
                rd_data_q <= rd_data_d;
                err_q     <= err_d;
            end
            case (state_q)
                IDLE: begin
                    if (req) begin
                        op_q    <= op_in;
                        f3_q    <= bus.Funct3;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wr_data;
                        cnt_q   <= WAIT_INIT;
                        state_q <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) state_q <= RESP;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // RAM contents survive reset; a store pending at reset is simply never committed.
    always_ff @(posedge clk) begin
        if (!reset && we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[cur_addr[ADDR_W-1:2]][8*b +: 8] <= st_word[8*b +: 8];
            end
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.ready   = ready_q;
    assign bus.mem_err = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: drivers push expected responses, per-DUT monitors pop on ready.
module tb_data_mem_responder;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    exp_t q0[$];
    exp_t q3[$];
    exp_t e0, e3;
    logic prev0 = 1'b0;
    logic prev3 = 1'b0;
    logic [31:0] model [128];

    always #5 clk = ~clk;

    data_mem_responder_if #(.ADDR_W(9), .DATA_W(32)) bus0 ();
    data_mem_responder_if #(.ADDR_W(9), .DATA_W(32)) bus3 ();

    data_mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    data_mem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [8:0] a, input logic [31:0] wd);
        if (sel == 0) begin
            bus0.MemRead = rd; bus0.MemWrite = wr; bus0.Funct3 = f3;
            bus0.addr = a; bus0.wr_data = wd;
        end else begin
            bus3.MemRead = rd; bus3.MemWrite = wr; bus3.Funct3 = f3;
            bus3.addr = a; bus3.wr_data = wd;
        end
    endtask

    // Called #1 after a posedge; returns #1 after the edge that raised ready.
    task automatic do_req(input int sel, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [8:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_d, input logic exp_e, input int exp_edges,
                          input string nm);
        exp_t x;
        int   edges;
        logic rdy;
        x.d = exp_d;
        x.e = exp_e;
        if (sel == 0) q0.push_back(x); else q3.push_back(x);
        drive(sel, rd, wr, f3, a, wd);
        edges = 0;
        rdy = 1'b0;
        while (!rdy && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
            rdy = (sel == 0) ? bus0.ready : bus3.ready;
        end
        total++;
        if (edges != exp_edges) begin
            bad++;
            $display("FAIL %s latency: got %0d edges want %0d", nm, edges, exp_edges);
        end
        drive(sel, 1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
    endtask

    always @(negedge clk) begin
        if (!reset && bus0.ready) begin
            total++;
            if (prev0) begin
                bad++;
                $display("FAIL dut0 ready_width: got 2 consecutive want 1");
            end
            if (q0.size() == 0) begin
                bad++;
                $display("FAIL dut0 unexpected_ready: got ready want none");
            end else begin
                e0 = q0.pop_front();
                if (bus0.rd_data !== e0.d || bus0.mem_err !== e0.e) begin
                    bad++;
                    $display("FAIL dut0 resp: got %h/%b want %h/%b",
                             bus0.rd_data, bus0.mem_err, e0.d, e0.e);
                end
            end
        end
        prev0 = bus0.ready;
    end

    always @(negedge clk) begin
        if (!reset && bus3.ready) begin
            total++;
            if (prev3) begin
                bad++;
                $display("FAIL dut3 ready_width: got 2 consecutive want 1");
            end
            if (q3.size() == 0) begin
                bad++;
                $display("FAIL dut3 unexpected_ready: got ready want none");
            end else begin
                e3 = q3.pop_front();
                if (bus3.rd_data !== e3.d || bus3.mem_err !== e3.e) begin
                    bad++;
                    $display("FAIL dut3 resp: got %h/%b want %h/%b",
                             bus3.rd_data, bus3.mem_err, e3.d, e3.e);
                end
            end
        end
        prev3 = bus3.ready;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
        drive(3, 1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst ready0", {31'b0, bus0.ready}, 32'h0);
        chk("rst rd0", bus0.rd_data, 32'h0);
        chk("rst err0", {31'b0, bus0.mem_err}, 32'h0);
        chk("rst ready3", {31'b0, bus3.ready}, 32'h0);

        // Zero wait states: full word, sub-word, errors.
        do_req(0, 0, 1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0,        0, 1, "SW 010");
        do_req(0, 1, 0, 3'b010, 9'h010, 32'h0,        32'hDEADBEEF, 0, 2, "LW 010");
        do_req(0, 0, 1, 3'b000, 9'h011, 32'h00000080, 32'h0,        0, 2, "SB 011");
        do_req(0, 1, 0, 3'b010, 9'h010, 32'h0,        32'hDEAD80EF, 0, 2, "LW 010 b");
        do_req(0, 1, 0, 3'b000, 9'h011, 32'h0,        32'hFFFFFF80, 0, 2, "LB 011");
        do_req(0, 1, 0, 3'b100, 9'h011, 32'h0,        32'h00000080, 0, 2, "LBU 011");
        do_req(0, 1, 0, 3'b001, 9'h012, 32'h0,        32'hFFFFDEAD, 0, 2, "LH 012");
        do_req(0, 1, 0, 3'b101, 9'h012, 32'h0,        32'h0000DEAD, 0, 2, "LHU 012");
        do_req(0, 0, 1, 3'b010, 9'h014, 32'h11223344, 32'h0,        0, 2, "SW 014");
        do_req(0, 1, 0, 3'b010, 9'h013, 32'h0,        32'h0,        1, 2, "LW 013 mis");
        do_req(0, 0, 1, 3'b001, 9'h015, 32'h0000FFFF, 32'h0,        1, 2, "SH 015 mis");
        do_req(0, 1, 0, 3'b011, 9'h010, 32'h0,        32'h0,        1, 2, "F3 011");
        do_req(0, 1, 1, 3'b010, 9'h010, 32'h0,        32'h0,        1, 2, "RD+WR");
        do_req(0, 0, 1, 3'b100, 9'h014, 32'h000000FF, 32'h0,        1, 2, "SBU illegal");
        do_req(0, 1, 0, 3'b010, 9'h010, 32'h0,        32'hDEAD80EF, 0, 2, "LW 010 kept");
        do_req(0, 1, 0, 3'b010, 9'h014, 32'h0,        32'h11223344, 0, 2, "LW 014 kept");
        do_req(0, 0, 1, 3'b001, 9'h016, 32'h0000BEEF, 32'h0,        0, 2, "SH 016");
        do_req(0, 1, 0, 3'b001, 9'h016, 32'h0,        32'hFFFFBEEF, 0, 2, "LH 016");
        do_req(0, 1, 0, 3'b010, 9'h014, 32'h0,        32'hBEEF3344, 0, 2, "LW 014 c");

        // Three wait states: latency, held request re-accept.
        do_req(3, 0, 1, 3'b010, 9'h020, 32'hAAAAAAAA, 32'h0,        0, 4, "W3 SW 020");
        do_req(3, 1, 0, 3'b010, 9'h020, 32'h0,        32'hAAAAAAAA, 0, 5, "W3 LW 020");
        do_req(3, 1, 0, 3'b010, 9'h020, 32'h0,        32'hAAAAAAAA, 0, 5, "W3 LW held");

        // Reset two cycles after accept drops the store.
        @(posedge clk); #1;
        drive(3, 1'b0, 1'b1, 3'b010, 9'h020, 32'h12345678);
        @(posedge clk); #1;
        drive(3, 1'b0, 1'b0, 3'b000, 9'h000, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst ready3", {31'b0, bus3.ready}, 32'h0);
        chk("midrst rd3", bus3.rd_data, 32'h0);
        chk("midrst err3", {31'b0, bus3.mem_err}, 32'h0);
        chk("midrst rd0", bus0.rd_data, 32'h0);
        repeat (8) @(posedge clk);
        #1;
        do_req(3, 1, 0, 3'b010, 9'h020, 32'h0, 32'hAAAAAAAA, 0, 4, "W3 LW after rst");

        // Back-to-back SW/LW over 128 words.
        for (int i = 0; i < 128; i++) begin
            model[i] = $urandom;
            do_req(0, 0, 1, 3'b010, 9'(i * 4), model[i], 32'h0, 0, (i == 0) ? 1 : 2, "b2b SW");
            do_req(0, 1, 0, 3'b010, 9'(i * 4), 32'h0, model[i], 0, 2, "b2b LW");
        end

        repeat (3) @(posedge clk);
        #1;
        chk("q0 drained", 32'(q0.size()), 32'h0);
        chk("q3 drained", 32'(q3.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
